// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline latch: valid/ready with a one-entry skid, flush-to-bubble and a saturating stall counter.
// One cycle from accept to out_valid; in_ready is registered and drops the cycle after the skid fills.
module pipe_stage_latch #(
    parameter int          WIDTH       = 32,
    parameter int          FIELDS      = 4,
    parameter int          INSTR_FIELD = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
    parameter int          CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FIELDS*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FIELDS*WIDTH-1:0] out_data,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt,
    input  logic                    stall_clr
);
    localparam int DW     = FIELDS * WIDTH;
    localparam int NW     = (WIDTH < 32) ? WIDTH : 32;
    localparam int IF_IDX = (INSTR_FIELD < FIELDS) ? INSTR_FIELD : 0;

    if (INSTR_FIELD >= FIELDS) begin : g_bad_instr_field
        $error("pipe_stage_latch: INSTR_FIELD must be below FIELDS");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] main_q, skid_q, bubble;
    logic          accept, consume;
    logic          main_ld_in, main_ld_skid, skid_ld;

    always_comb begin
        bubble = '0;
        for (int b = 0; b < NW; b++) begin
            bubble[IF_IDX*WIDTH + b] = NOP_INSTR[b];
        end
    end

    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_q : bubble;
    assign occupancy = state;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != SKID);
        end
    end

    always_comb begin
        state_nxt    = state;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt  = FULL;
                    main_ld_in = 1'b1;
                end
            end
            FULL: begin
                if (accept && consume) begin
                    main_ld_in = 1'b1;
                end else if (consume) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    state_nxt = SKID;
                    skid_ld   = 1'b1;
                end
            end
            SKID: begin
                if (consume) begin
                    state_nxt    = FULL;
                    main_ld_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A same-cycle consume is already delivered; only held entries and the offered input are squashed.
        if (flush) begin
            state_nxt    = EMPTY;
            main_ld_in   = 1'b0;
            main_ld_skid = 1'b0;
            skid_ld      = 1'b0;
        end
    end

    // Payload needs no reset: it is only visible while its valid state is set.
    always_ff @(posedge clk) begin
        if (main_ld_in) begin
            main_q <= in_data;
        end else if (main_ld_skid) begin
            main_q <= skid_q;
        end
        if (skid_ld) begin
            skid_q <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch: stimulus pushes accepted words into a scoreboard queue, a negedge monitor pops on every consume.
module tb_pipe_stage_latch;
    localparam int W = 32;
    localparam int F = 4;
    localparam int DW = W * F;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [3:0]    stall_cnt;
    logic          stall_clr;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    localparam logic [DW-1:0] BUB = {32'h0, 32'h0, 32'h0000_0013, 32'h0};

    pipe_stage_latch #(
        .WIDTH(W), .FIELDS(F), .INSTR_FIELD(1), .NOP_INSTR(32'h0000_0013), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [31:0] pc);
        return {pc ^ 32'hBBBB_0000, pc ^ 32'h0000_AA00, 32'h1000_0000 | pc, pc};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_rdy is the hand-derived in_ready for this cycle; the word is expected downstream only if accepted.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic exp_rdy);
        in_valid = v;
        in_data  = d;
        chk("in_ready", {127'b0, in_ready}, {127'b0, exp_rdy});
        if (v && exp_rdy && !flush) exp_q.push_back(d);
        tick();
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", out_data);
            end else begin
                chk("scoreboard", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stall_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_out_valid", {127'b0, out_valid}, '0);
        chk("rst_in_ready", {127'b0, in_ready}, {127'b0, 1'b1});
        chk("rst_occupancy", {126'b0, occupancy}, '0);
        chk("rst_out_data", out_data, BUB);
        chk("rst_stall_cnt", {124'b0, stall_cnt}, '0);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, mk(i), 1'b1);
            chk("stream_data", out_data, mk(i));
            chk("stream_occ", {126'b0, occupancy}, {126'b0, 2'd1});
        end
        drive(1'b0, '0, 1'b1);
        chk("stream_drain_occ", {126'b0, occupancy}, '0);
        chk("stream_stall", {124'b0, stall_cnt}, '0);

        // Back-pressure: A to head, B to skid, C refused until space frees
        out_ready = 1'b0;
        drive(1'b1, mk(32'h10), 1'b1);
        drive(1'b1, mk(32'h20), 1'b1);
        chk("bp_occ_skid", {126'b0, occupancy}, {126'b0, 2'd2});
        drive(1'b1, mk(32'h30), 1'b0);
        drive(1'b1, mk(32'h30), 1'b0);
        chk("bp_stall", {124'b0, stall_cnt}, {124'b0, 4'd3});
        chk("bp_head", out_data, mk(32'h10));
        out_ready = 1'b1;
        drive(1'b1, mk(32'h30), 1'b0);
        drive(1'b1, mk(32'h30), 1'b1);
        drive(1'b0, '0, 1'b1);
        chk("bp_drained", {126'b0, occupancy}, '0);
        chk("bp_stall_hold", {124'b0, stall_cnt}, {124'b0, 4'd3});

        // Flush while SKID with D offered
        out_ready = 1'b0;
        drive(1'b1, mk(32'h50), 1'b1);
        drive(1'b1, mk(32'h60), 1'b1);
        exp_q.delete();
        flush = 1'b1;
        drive(1'b1, mk(32'h40), 1'b0);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", {126'b0, occupancy}, '0);
        chk("flush_out_valid", {127'b0, out_valid}, '0);
        chk("flush_bubble", out_data, BUB);
        chk("flush_in_ready", {127'b0, in_ready}, {127'b0, 1'b1});
        chk("flush_keeps_stall", {124'b0, stall_cnt}, {124'b0, 4'd5});
        // Flush while EMPTY with in_ready=1: input still dropped
        flush = 1'b1;
        drive(1'b1, mk(32'h41), 1'b1);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, 1'b1);
        chk("flush_drop_occ", {126'b0, occupancy}, '0);
        // Consume in the flush cycle is delivered
        drive(1'b1, mk(32'h70), 1'b1);
        flush = 1'b1;
        drive(1'b0, '0, 1'b1);
        flush = 1'b0;
        chk("flush_consume_occ", {126'b0, occupancy}, '0);

        // Saturation and clear
        out_ready = 1'b0;
        drive(1'b1, mk(32'h80), 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", {124'b0, stall_cnt}, {124'b0, 4'd15});
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("clr_wins", {124'b0, stall_cnt}, '0);
        tick();
        chk("count_after_clr", {124'b0, stall_cnt}, {124'b0, 4'd1});
        out_ready = 1'b1;
        drive(1'b0, '0, 1'b1);
        chk("sat_drained", {126'b0, occupancy}, '0);

        // Asynchronous reset in the middle of a SKID cycle
        out_ready = 1'b0;
        drive(1'b1, mk(32'h90), 1'b1);
        drive(1'b1, mk(32'hA0), 1'b1);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_out_valid", {127'b0, out_valid}, '0);
        chk("arst_occ", {126'b0, occupancy}, '0);
        chk("arst_in_ready", {127'b0, in_ready}, {127'b0, 1'b1});
        chk("arst_out_data", out_data, BUB);
        chk("arst_stall", {124'b0, stall_cnt}, '0);
        tick();
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        drive(1'b1, mk(32'hB0), 1'b1);
        chk("arst_first_after", out_data, mk(32'hB0));
        drive(1'b0, '0, 1'b1);
        tick();

        chk("scoreboard_empty", DW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_latch.md
# pipe_stage_latch

Parametrised pipeline-stage register for the processor's inter-stage latches (F/D, D/X, X/M, M/W). It carries FIELDS words of WIDTH bits each, and adds the following over the fixed four-word, enable-only latches:
- a valid/ready handshake;
- a one-entry skid buffer, so upstream sees a registered ready;
- a synchronous flush that injects a NOP bubble;
- a saturating stall counter for performance debug.

## Interface
Parameters:
- WIDTH, 32, bits per field
- FIELDS, 4, number of fields (conventional order: 0 pc_plus_1, 1 instruction, 2 O, 3 B)
- INSTR_FIELD, 1, index of the field forced to NOP_INSTR on bubble/flush
- NOP_INSTR, 32'h0000_0000, instruction encoding for a bubble (low WIDTH bits used)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream presents in_data
- in_ready  out  1  stage can accept this cycle (registered)
- in_data  in  FIELDS*WIDTH  field k at [k*WIDTH +: WIDTH]
- out_valid  out  1  out_data holds a live instruction
- out_ready  in  1  downstream consumes this cycle
- out_data  out  FIELDS*WIDTH  head entry, or bubble pattern when invalid
- occupancy  out  2  entries held (0, 1, 2)
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating
- stall_clr  in  1  synchronous clear of stall_cnt

## Operation
- Storage: main entry (head) plus skid entry, each with its own valid bit.
- Definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- State machine, encoded by the valid bits:
  - EMPTY (0 entries):
    - in_ready=1.
    - accept -> FULL, with main <= in_data.
  - FULL (1 entry):
    - in_ready=1.
    - accept & consume -> FULL, main <= in_data.
    - consume & !accept -> EMPTY.
    - accept & !consume -> SKID, skid <= in_data.
  - SKID (2 entries):
    - in_ready=0.
    - consume -> FULL, main <= skid.
    - no consume -> hold.
- in_ready is a flop: next value = !(next state == SKID).
- Ordering: entries leave strictly in acceptance order; no drop, no duplication.
- Bubble pattern: when out_valid=0, out_data has field INSTR_FIELD = NOP_INSTR[WIDTH-1:0] and all other fields = 0.
- flush: highest priority below reset.
  - Next state EMPTY; both valid bits cleared; in_ready=1 next cycle.
  - Any in_data offered in the flush cycle is discarded, even if in_ready=1.
  - A consume in the same cycle still counts as delivered; downstream owns it.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - stall_clr zeroes it and wins over an increment in the same cycle.
  - flush does not clear it.
- occupancy: 0/1/2 for EMPTY/FULL/SKID.

## Timing
- Reset (asynchronous assert, release on clock domain):
  - state EMPTY, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
  - out_data = bubble pattern.
  - Skid contents are don't-care but must never be visible.
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle) when the stage was EMPTY or is draining.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Back-pressure: upstream sees in_ready fall one cycle after the skid fills, never combinationally from out_ready.
- Reset mid-operation: both entries lost immediately (asynchronous); outputs go to reset values without waiting for a clock edge.
- Simultaneous cases:
  - flush + reset: reset wins.
  - flush + accept: input dropped.
  - SKID + consume + in_valid: no accept (in_ready=0).
- FIELDS=1 with INSTR_FIELD=0 is legal. INSTR_FIELD >= FIELDS is illegal; flagged by a simulation-time check.

## Test plan
- Reset then idle: out_valid=0, in_ready=1, occupancy=0, out_data instruction field = NOP_INSTR, others 0.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with pc_plus_1 = 1..8. Required:
  - out_data pc_plus_1 sequence 1..8, each one cycle after its accept.
  - occupancy stays 1; stall_cnt stays 0.
- Back-pressure:
  - Stimulus: accept A=0x10, then hold out_ready=0 and offer B=0x20, C=0x30.
  - B lands in skid; in_ready=0 on the next cycle; C is not accepted.
  - stall_cnt counts each held cycle.
  - Release out_ready: A, B, then C delivered in order.
- Flush in SKID with in_valid=1 (D=0x40):
  - Next cycle occupancy=0, out_valid=0, bubble pattern on out_data, in_ready=1.
  - D never appears on out_data.
- Saturation: CNT_W=4, stall for 20 cycles -> stall_cnt=15. stall_clr concurrent with a stall cycle -> stall_cnt=0.
- Asynchronous reset asserted mid-SKID between clock edges: outputs go to reset values before the next edge, and the first entry accepted after release is the first delivered.
